// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: steps a single-bit combinational ALU once per clock.
// Build option ALU_SEQ_COUNT_MASK_EN masks the count to 5 bits (80186 style); default uses all 8 bits.
`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif

package alu_shift_sequencer_pkg;
    localparam int ALU_OP_W = `MC_ALUOp_t_BITS;
    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALUOp_SELA = alu_op_t'(0);
    localparam alu_op_t ALUOp_ADD  = alu_op_t'(1);
    localparam alu_op_t ALUOp_SHR  = alu_op_t'(2);
    localparam alu_op_t ALUOp_SHL  = alu_op_t'(3);
    localparam alu_op_t ALUOp_SAR  = alu_op_t'(4);
    localparam alu_op_t ALUOp_ROR  = alu_op_t'(5);
    localparam alu_op_t ALUOp_ROL  = alu_op_t'(6);
    localparam alu_op_t ALUOp_RCL  = alu_op_t'(7);
    localparam alu_op_t ALUOp_RCR  = alu_op_t'(8);

    localparam int FLAG_CF = 0;
endpackage

module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  alu_op_t       op,
    input  logic          is_8_bit,
    input  logic [15:0]   value,
    input  logic [7:0]    count,
    input  logic [15:0]   flags_in,
    output logic          busy,
    output logic          done,
    output logic [15:0]   result,
    output logic [15:0]   flags_out,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    output alu_op_t       alu_op,
    output logic          alu_is_8_bit,
    output logic [15:0]   alu_flags_in,
    input  logic [15:0]   alu_out,
    input  logic [15:0]   alu_flags_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e      state_q;
    logic [15:0] acc_q;
    logic [15:0] flg_q;
    logic [15:0] result_q;
    logic [15:0] flags_out_q;
    logic [7:0]  rem_q;
    alu_op_t     alu_op_q;
    logic        is8_q;
    logic [7:0]  eff_count;

`ifdef ALU_SEQ_COUNT_MASK_EN
    assign eff_count = count & 8'h1F;
`else
    assign eff_count = count;
`endif

    function automatic logic is_shift_op(input alu_op_t o);
        case (o)
            ALUOp_SHR, ALUOp_SHL, ALUOp_SAR,
            ALUOp_ROR, ALUOp_ROL, ALUOp_RCL, ALUOp_RCR: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= 16'h0000;
            flg_q       <= 16'h0000;
            result_q    <= 16'h0000;
            flags_out_q <= 16'h0000;
            rem_q       <= 8'h00;
            alu_op_q    <= ALUOp_SELA;
            is8_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q <= value;
                        flg_q <= flags_in;
                        is8_q <= is_8_bit;
                        if (eff_count == 8'h00 || !is_shift_op(op)) begin
                            state_q     <= ST_DONE;
                            result_q    <= value;
                            flags_out_q <= flags_in;
                        end else begin
                            state_q  <= ST_RUN;
                            rem_q    <= eff_count;
                            alu_op_q <= op;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q  <= ST_IDLE;
                        alu_op_q <= ALUOp_SELA;
                    end else begin
                        acc_q <= alu_out;
                        flg_q <= alu_flags_out;
                        rem_q <= rem_q - 8'd1;
                        // Last step: publish the ALU result directly so it is valid in the done cycle.
                        if (rem_q == 8'd1) begin
                            state_q     <= ST_DONE;
                            alu_op_q    <= ALUOp_SELA;
                            result_q    <= alu_out;
                            flags_out_q <= alu_flags_out;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign result       = result_q;
    assign flags_out    = flags_out_q;
    assign alu_a        = acc_q;
    assign alu_b        = 16'h0001;
    assign alu_op       = alu_op_q;
    assign alu_is_8_bit = is8_q;
    assign alu_flags_in = flg_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a behavioural single-bit shift ALU.
// Expected values are hand-computed; the RCL case follows ALU_SEQ_COUNT_MASK_EN.
module tb_alu_shift_sequencer;
    import alu_shift_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    alu_op_t     op;
    logic        is_8_bit;
    logic [15:0] value;
    logic [7:0]  count;
    logic [15:0] flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] flags_out;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    alu_op_t     alu_op;
    logic        alu_is_8_bit;
    logic [15:0] alu_flags_in;
    logic [15:0] alu_out;
    logic [15:0] alu_flags_out;

    int n_checks   = 0;
    int n_failures = 0;

    always #5 clk = ~clk;

    alu_shift_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .op            (op),
        .is_8_bit      (is_8_bit),
        .value         (value),
        .count         (count),
        .flags_in      (flags_in),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .flags_out     (flags_out),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_is_8_bit  (alu_is_8_bit),
        .alu_flags_in  (alu_flags_in),
        .alu_out       (alu_out),
        .alu_flags_out (alu_flags_out)
    );

    // Single-bit shift ALU; in byte mode the upper byte passes through.
    logic msb, fill, cf_out, left;
    always_comb begin
        alu_out       = alu_a;
        alu_flags_out = alu_flags_in;
        msb           = alu_is_8_bit ? alu_a[7] : alu_a[15];
        fill          = 1'b0;
        left          = 1'b0;
        cf_out        = 1'b0;
        case (alu_op)
            ALUOp_SHL: begin left = 1'b1; fill = 1'b0;            end
            ALUOp_ROL: begin left = 1'b1; fill = msb;             end
            ALUOp_RCL: begin left = 1'b1; fill = alu_flags_in[0]; end
            ALUOp_SHR: fill = 1'b0;
            ALUOp_SAR: fill = msb;
            ALUOp_ROR: fill = alu_a[0];
            ALUOp_RCR: fill = alu_flags_in[0];
            default:   fill = 1'b0;
        endcase
        if (alu_op != ALUOp_SELA && alu_op != ALUOp_ADD) begin
            if (left) begin
                cf_out  = msb;
                alu_out = alu_is_8_bit ? {alu_a[15:8], alu_a[6:0], fill} : {alu_a[14:0], fill};
            end else begin
                cf_out  = alu_a[0];
                alu_out = alu_is_8_bit ? {alu_a[15:8], fill, alu_a[7:1]} : {fill, alu_a[15:1]};
            end
            alu_flags_out[FLAG_CF] = cf_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents start for one cycle (T); returns at mid-cycle T+1.
    task automatic launch(input alu_op_t o, input logic b8, input logic [15:0] v,
                          input logic [7:0] c, input logic [15:0] f);
        @(negedge clk);
        op = o; is_8_bit = b8; value = v; count = c; flags_in = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns in the done cycle (or after a bounded timeout, which fails the latency check).
    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 1;
        int busy_n = 0;
        while (done !== 1'b1 && lat < 300) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) busy_n++;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_n, exp_lat);
    endtask

    logic [15:0] exp_rcl_res, exp_rcl_flg;
    int          exp_rcl_lat;
    logic        saw_done;

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; op = ALUOp_SELA;
        is_8_bit = 1'b0; value = 16'h0; count = 8'h0; flags_in = 16'h0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 16'h0000);
        check("rst_flags", flags_out, 16'h0000);
        check("rst_alu_op", alu_op, ALUOp_SELA);
        check("rst_alu_a", alu_a, 16'h0000);
        check("rst_alu_b", alu_b, 16'h0001);
        @(negedge clk);
        reset_n = 1'b1;

        // SHL byte, 0x81 << 1: low byte 0x02, CF from bit 7.
        launch(ALUOp_SHL, 1'b1, 16'h0081, 8'd1, 16'h0000);
        check("shl8_alu_op_run", alu_op, ALUOp_SHL);
        wait_done("shl8", 2);
        check("shl8_result", result, 16'h0002);
        check("shl8_flags", flags_out, 16'h0001);
        // start during done must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", busy, 0);
        @(negedge clk);
        check("start_in_done_still_idle", busy, 0);

        // SHR 16-bit, 0x8000 >> 15 = 0x0001, last bit out is 0 so CF clears.
        launch(ALUOp_SHR, 1'b0, 16'h8000, 8'd15, 16'h0001);
        check("shr_alu_a_first", alu_a, 16'h8000);
        wait_done("shr15", 16);
        check("shr15_result", result, 16'h0001);
        check("shr15_flags", flags_out, 16'h0000);

        // Count 0: pass-through, ALU op stays SELA.
        launch(ALUOp_ROL, 1'b0, 16'h1234, 8'd0, 16'h0ACD);
        check("rol0_alu_op", alu_op, ALUOp_SELA);
        wait_done("rol0", 1);
        check("rol0_result", result, 16'h1234);
        check("rol0_flags", flags_out, 16'h0ACD);

        // Non-shift op: immediate done with operand returned.
        launch(ALUOp_ADD, 1'b0, 16'hBEEF, 8'd5, 16'h0840);
        wait_done("invalid_op", 1);
        check("invalid_op_result", result, 16'hBEEF);
        check("invalid_op_flags", flags_out, 16'h0840);

        // RCL byte of 0x80 with CF=1, count 33: masked -> 1 step; else 33 mod 9 = 6 steps of a 9-bit rotate.
`ifdef ALU_SEQ_COUNT_MASK_EN
        exp_rcl_lat = 2; exp_rcl_res = 16'h0001; exp_rcl_flg = 16'h0001;
`else
        exp_rcl_lat = 34; exp_rcl_res = 16'h0030; exp_rcl_flg = 16'h0000;
`endif
        launch(ALUOp_RCL, 1'b1, 16'h0080, 8'd33, 16'h0001);
        wait_done("rcl33", exp_rcl_lat);
        check("rcl33_result", result, exp_rcl_res);
        check("rcl33_flags", flags_out, exp_rcl_flg);

        // SAR count 10 aborted in T+4.
        launch(ALUOp_SAR, 1'b0, 16'h8000, 8'd10, 16'h0000);
        saw_done = done;
        repeat (3) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        saw_done = saw_done | done;
        check("abort_idle", busy, 0);
        check("abort_no_done", saw_done, 0);
        check("abort_result_kept", result, exp_rcl_res);
        check("abort_flags_kept", flags_out, exp_rcl_flg);
        // Restart at T+6: 0x8003 SAR 2 -> 0xE000, CF=1.
        launch(ALUOp_SAR, 1'b0, 16'h8003, 8'd2, 16'h0000);
        wait_done("sar_restart", 3);
        check("sar_restart_result", result, 16'hE000);
        check("sar_restart_flags", flags_out, 16'h0001);

        // Reset mid-operation at T+3.
        launch(ALUOp_SHL, 1'b0, 16'h0001, 8'd8, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 16'h0000);
        check("midrst_flags", flags_out, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        // 0x4001 SHL 2 -> 0x0004, CF=1 from the second step.
        launch(ALUOp_SHL, 1'b0, 16'h4001, 8'd2, 16'h0000);
        wait_done("post_rst", 3);
        check("post_rst_result", result, 16'h0004);
        check("post_rst_flags", flags_out, 16'h0001);
        @(negedge clk);
        check("post_rst_busy_fall", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/alu_shift_sequencer.md
# alu_shift_sequencer

Multi-cycle controller that runs shift and rotate instructions by a variable count (CL or immediate) on the shared combinational ALU, one single-bit ALU step per clock. It sits between the microcode engine and the ALU datapath. It captures the operand, count and flags, drives the ALU inputs each cycle, feeds the ALU result and flags back as the next step's inputs, and returns the final value and flags with a done pulse.

## Interface
- No parameters. ALU op width is `MC_ALUOp_t_BITS`.
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  launch request; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE with no done pulse
- op  input  `MC_ALUOp_t_BITS`  one of ALUOp_SHR/SHL/SAR/ROR/ROL/RCL/RCR
- is_8_bit  input  1  byte operation
- value  input  16  operand to shift
- count  input  8  shift count
- flags_in  input  16  flags at launch
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- result  output  16  final value; held until the next launch
- flags_out  output  16  final flags; held until the next launch
- alu_a  output  16  running accumulator to the ALU
- alu_b  output  16  constant 16'h0001
- alu_op  output  `MC_ALUOp_t_BITS`  latched op in RUN, ALUOp_SELA otherwise
- alu_is_8_bit  output  1  latched is_8_bit
- alu_flags_in  output  16  running flags to the ALU
- alu_out  input  16  ALU result, combinational from the alu_* outputs
- alu_flags_out  input  16  ALU flags, combinational

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start:
  - Latch op, is_8_bit, the effective count, acc=value and flg=flags_in.
  - Effective count 0 or op not a shift/rotate: go to DONE. acc and flg are unchanged; result=value, flags_out=flags_in.
  - Otherwise: go to RUN with rem=effective count.
- RUN, each cycle:
  - acc<=alu_out, flg<=alu_flags_out, rem<=rem-1.
  - When rem==1 at the update, go to DONE.
- DONE: done=1 for exactly one cycle. result<=acc and flags_out<=flg are registered on entry. Then go to IDLE.
- start is ignored outside IDLE. start in the cycle done is high is also ignored; it must be re-presented in IDLE.
- abort takes priority over every other transition from RUN or DONE. It forces IDLE and leaves result/flags_out at their previous values. abort in IDLE has no effect.
- Byte operations: the ALU masks to 8 bits. acc[15:8] passes through whatever the ALU returns, and the sequencer does not mask it.
- Reset values: state=IDLE, busy=0, done=0, result=0, flags_out=0, acc=0, flg=0, rem=0, alu_op=ALUOp_SELA.

## Timing
- Launch cycle T (start sampled in IDLE). RUN occupies cycles T+1..T+N.
- done is high in cycle T+N+1 for effective count N≥1, and in cycle T+1 for count 0 or an invalid op.
- result/flags_out are valid from the done cycle onward.
- busy rises in T+1 and falls in the cycle after done.
- The ALU path is combinational inside one cycle: alu_* outputs are registered and alu_out is captured at the next edge.
- Reset asserted mid-operation: all state returns to reset values immediately and no done pulse is produced. After reset_n rises, the first start is accepted on the next clock edge.

## Configuration
- ALU_SEQ_COUNT_MASK_EN defined: effective count = count & 8'h1F (80186-style masking; maximum 31 iterations).
- ALU_SEQ_COUNT_MASK_EN undefined: the full 8-bit count is used (8086 behaviour; up to 255 iterations).

## Test plan
- SHL, is_8_bit=1, value=16'h0081, count=1, flags_in=0 at T → done at T+2, result[7:0]=8'h02, flags_out[CF]=1, busy high T+1..T+2.
- SHR, 16-bit, value=16'h8000, count=15 → done at T+16, result=16'h0001, CF=0; rem reaches 0 exactly at the DONE transition.
- ROL, 16-bit, value=16'h1234, count=0, flags_in=16'h0ACD → done at T+1, result=16'h1234, flags_out=16'h0ACD, alu_op stays ALUOp_SELA.
- RCL, 8-bit, value=16'h0080, CF=1, count=33:
  - With ALU_SEQ_COUNT_MASK_EN: 1 iteration, done at T+2, result[7:0]=8'h01, CF=1.
  - Without it: 33 iterations, done at T+34, and the result matches a 9-bit rotate model.
- SAR count=10 with abort at T+4 → state IDLE at T+5, no done pulse, result/flags_out keep their previous values. A new start at T+6 completes normally.
- reset_n low at T+3 of a count=8 SHL → busy=0, done=0, result=0 asynchronously. After release, start with count=2 → done 3 cycles later with the correct value.
